mem_pause_seq: RTL and testbench

//  Sequences IF instruction fetches and MEM data accesses onto one single-port
//  req/ready system bus. Produces the global `pause` consumed by the pipeline hazard

---
 rtl/mem_pause_seq_pkg.sv | 23 ++
 rtl/mem_pause_seq_wdt.sv | 33 +++
 rtl/mem_pause_seq.sv | 156 +++++++++++++++
 tb/tb_mem_pause_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pause_seq_pkg.sv
// Shared types and defaults for the IF/MEM bus sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pause_seq_pkg;

   // Sequencer states: idle, data transfer, instruction fetch, one-cycle release.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DATA  = 2'd1,
      S_FETCH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Default bus wait limit and the watchdog counter width that can hold it.
   localparam int DEF_TIMEOUT_CYCLES = 255;
   localparam int DEF_CNT_W          = 8;

   // True while a bus transfer is being sequenced (pipeline must stay frozen).
   function automatic logic is_bus_state(input state_t s);
      return (s == S_DATA) || (s == S_FETCH);
   endfunction

endpackage

// File: rtl/mem_pause_seq_wdt.sv
// Bus watchdog: counts wait cycles of one transfer and flags expiry.
// Latency: expire is combinational in the TIMEOUT_CYCLES-th waiting cycle.
// Backpressure: none; run/clr come straight from the bus handshake.
// Ports: clk, rst (sync, active-high); run = transfer waiting this cycle;
//        clr = no transfer outstanding; expire = abort the transfer now.
module mem_pause_seq_wdt
   import mem_pause_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic expire
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= cnt + 1'b1;
      end
   end

   // cnt holds the number of wait cycles already spent, so the current cycle
   // is wait number cnt+1.
   assign expire = run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_pause_seq.sv
// Sequences MEM data accesses and IF fetches onto one req/ready bus; drives pipeline pause.
// Latency: fetch alone 3 cycles, data+fetch 5 cycles, plus bus wait states.
// Backpressure: pause freezes the pipeline until all requests of the cycle are served.
// Optional feature macro: BUS_TIMEOUT_EN (bus watchdog, abort and bus_err pulse).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req, if_addr          instruction fetch request from IF
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be   data access from MEM
//   bus_ready, bus_rdata     bus completion and read data
//   bus_req, bus_we, bus_addr, bus_wdata, bus_be   registered bus request
//   pause                    pipeline freeze (combinational)
//   if_rdata, mem_rdata      results, valid in the DONE cycle
//   bus_err                  one-cycle pulse in DONE after a timed-out transfer
module mem_pause_seq
   import mem_pause_seq_pkg::*;
#(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   input  logic            mem_req,
   input  logic            mem_we,
   input  logic [AW-1:0]   mem_addr,
   input  logic [DW-1:0]   mem_wdata,
   input  logic [DW/8-1:0] mem_be,
   input  logic            bus_ready,
   input  logic [DW-1:0]   bus_rdata,
   output logic            bus_req,
   output logic            bus_we,
   output logic [AW-1:0]   bus_addr,
   output logic [DW-1:0]   bus_wdata,
   output logic [DW/8-1:0] bus_be,
   output logic            pause,
   output logic [DW-1:0]   if_rdata,
   output logic [DW-1:0]   mem_rdata,
   output logic            bus_err
);

   if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
      $error("mem_pause_seq: CNT_W too small for TIMEOUT_CYCLES");
   end

   state_t state, state_nxt;
   logic   xfer_abort;
   logic   xfer_done;

`ifdef BUS_TIMEOUT_EN
   logic err_flag;

   mem_pause_seq_wdt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_wdt (
      .clk    (clk),
      .rst    (rst),
      .run    (bus_req & ~bus_ready),
      .clr    (~bus_req),
      .expire (xfer_abort)
   );

   // Remembers an aborted transfer until the release cycle reports it.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_flag <= 1'b0;
      end else if (xfer_abort) begin
         err_flag <= 1'b1;
      end else if (state == S_DONE) begin
         err_flag <= 1'b0;
      end
   end

   assign bus_err = (state == S_DONE) && err_flag;
`else
   assign xfer_abort = 1'b0;
   assign bus_err    = 1'b0;
`endif

   // A ready seen while bus_req is low (gap cycle, after reset) is not ours.
   assign xfer_done = bus_req && (bus_ready || xfer_abort);

   always_comb begin
      state_nxt = state;
      pause     = is_bus_state(state);
      case (state)
         S_IDLE: begin
            // MEM holds the older instruction, so it is served first.
            if (mem_req) begin
               state_nxt = S_DATA;
               pause     = 1'b1;
            end else if (if_req) begin
               state_nxt = S_FETCH;
               pause     = 1'b1;
            end
         end
         S_DATA: begin
            if (xfer_done) begin
               state_nxt = if_req ? S_FETCH : S_DONE;
            end
         end
         S_FETCH: begin
            if (xfer_done) begin
               state_nxt = S_DONE;
            end
         end
         // Requests seen here belong to the instruction advancing at this edge.
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
      end else begin
         state <= state_nxt;
         if (xfer_done) begin
            // Drop the request after completion; in DATA->FETCH this yields the
            // one idle bus cycle between the two transfers.
            bus_req <= 1'b0;
            if (state == S_FETCH) begin
               if_rdata <= xfer_abort ? '0 : bus_rdata;
            end else if (!bus_we) begin
               mem_rdata <= xfer_abort ? '0 : bus_rdata;
            end
         end else if (!bus_req) begin
            if (state == S_IDLE && state_nxt == S_DATA) begin
               bus_req   <= 1'b1;
               bus_we    <= mem_we;
               bus_addr  <= mem_addr;
               bus_wdata <= mem_wdata;
               bus_be    <= mem_we ? mem_be : '1;
            end else if (state_nxt == S_FETCH) begin
               // Covers IDLE->FETCH and the gap cycle after a data transfer.
               bus_req   <= 1'b1;
               bus_we    <= 1'b0;
               bus_addr  <= if_addr;
               bus_wdata <= '0;
               bus_be    <= '1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_pause_seq.sv
// Directed bench for mem_pause_seq: fetch, load+fetch, waited store, reset
// mid-transfer, idle, and the optional bus timeout.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_mem_pause_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        bus_ready;
   logic [31:0] bus_rdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        pause;
   logic [31:0] if_rdata;
   logic [31:0] mem_rdata;
   logic        bus_err;

   int n_checks = 0;
   int n_fail   = 0;

   mem_pause_seq #(
      .AW(32), .DW(32), .TIMEOUT_CYCLES(4), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be),
      .pause(pause), .if_rdata(if_rdata), .mem_rdata(mem_rdata),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // Advance to 1 unit after the next rising edge (input drive point).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req    = 1'b0;
      if_addr   = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      bus_ready = 1'b0;
      bus_rdata = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step(); step();
      #1;
      n_checks++;
      if ({bus_req, bus_we, pause, bus_err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: req/we/pause/err got %b expected 0000",
                  {bus_req, bus_we, pause, bus_err});
      end
      n_checks++;
      if ({bus_addr, bus_wdata, bus_be, if_rdata, mem_rdata} !== 132'd0) begin
         n_fail++;
         $display("FAIL reset_data: addr %h wdata %h be %h if_rdata %h mem_rdata %h expected all 0",
                  bus_addr, bus_wdata, bus_be, if_rdata, mem_rdata);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_fetch();
      // IDLE: request appears, pause combinationally high.
      if_req = 1'b1; if_addr = 32'h0040_0000;
      #1;
      n_checks++;
      if ({pause, bus_req} !== 2'b10) begin
         n_fail++;
         $display("FAIL fetch_idle: pause/req got %b expected 10", {pause, bus_req});
      end
      step();
      // FETCH: bus driven, ready on the first cycle.
      bus_ready = 1'b1; bus_rdata = 32'h2402_0001;
      #1;
      n_checks++;
      if ({pause, bus_req, bus_we, bus_be, bus_addr} !== {3'b110, 4'hF, 32'h0040_0000}) begin
         n_fail++;
         $display("FAIL fetch_bus: pause %b req %b we %b be %h addr %h expected 1 1 0 f 00400000",
                  pause, bus_req, bus_we, bus_be, bus_addr);
      end
      step();
      // DONE: released for one cycle with the instruction.
      bus_ready = 1'b0; bus_rdata = '0;
      #1;
      n_checks++;
      if ({pause, bus_req} !== 2'b00 || if_rdata !== 32'h2402_0001) begin
         n_fail++;
         $display("FAIL fetch_done: pause %b req %b if_rdata %h expected 0 0 24020001",
                  pause, bus_req, if_rdata);
      end
      if_req = 1'b0;
      step();
      #1;
      n_checks++;
      if (pause !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_after: pause got %b expected 0", pause);
      end
   endtask

   task automatic test_back_to_back();
      if_req = 1'b1; if_addr = 32'h0040_0004;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1000_0000; mem_be = 4'hF;
      #1;
      n_checks++;
      if (pause !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_idle: pause got %b expected 1", pause);
      end
      step();
      // DATA first: MEM beats IF.
      bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
      #1;
      n_checks++;
      if ({pause, bus_req, bus_we, bus_be, bus_addr} !== {3'b110, 4'hF, 32'h1000_0000}) begin
         n_fail++;
         $display("FAIL b2b_data: pause %b req %b we %b be %h addr %h expected 1 1 0 f 10000000",
                  pause, bus_req, bus_we, bus_be, bus_addr);
      end
      step();
      // Gap cycle: bus idle, still paused, load data captured.
      bus_ready = 1'b0; bus_rdata = '0;
      #1;
      n_checks++;
      if ({pause, bus_req} !== 2'b10 || mem_rdata !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL b2b_gap: pause %b req %b mem_rdata %h expected 1 0 12345678",
                  pause, bus_req, mem_rdata);
      end
      step();
      bus_ready = 1'b1; bus_rdata = 32'h8C08_0000;
      #1;
      n_checks++;
      if ({pause, bus_req, bus_we, bus_be, bus_addr} !== {3'b110, 4'hF, 32'h0040_0004}) begin
         n_fail++;
         $display("FAIL b2b_fetch: pause %b req %b we %b be %h addr %h expected 1 1 0 f 00400004",
                  pause, bus_req, bus_we, bus_be, bus_addr);
      end
      step();
      bus_ready = 1'b0; bus_rdata = '0;
      #1;
      n_checks++;
      if (pause !== 1'b0 || if_rdata !== 32'h8C08_0000 || mem_rdata !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL b2b_done: pause %b if_rdata %h mem_rdata %h expected 0 8c080000 12345678",
                  pause, if_rdata, mem_rdata);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_store_wait();
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1000_0010;
      mem_wdata = 32'hDEAD_BEEF; mem_be = 4'b0011;
      step();
      // Four DATA cycles: three wait states then ready; fields must not move.
      for (int i = 0; i < 4; i++) begin
         bus_ready = (i == 3);
         bus_rdata = 32'hFFFF_FFFF;
         #1;
         n_checks++;
         if ({pause, bus_req, bus_we, bus_be, bus_addr, bus_wdata} !==
             {3'b111, 4'b0011, 32'h1000_0010, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL store_stable[%0d]: pause %b req %b we %b be %h addr %h wdata %h expected 1 1 1 3 10000010 deadbeef",
                     i, pause, bus_req, bus_we, bus_be, bus_addr, bus_wdata);
         end
         step();
      end
      bus_ready = 1'b0; bus_rdata = '0;
      #1;
      n_checks++;
      if ({pause, bus_req} !== 2'b00 || mem_rdata !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL store_done: pause %b req %b mem_rdata %h expected 0 0 12345678",
                  pause, bus_req, mem_rdata);
      end
      idle_inputs();
      step();
   endtask

`ifdef BUS_TIMEOUT_EN
   task automatic test_timeout();
      if_req = 1'b1; if_addr = 32'h0040_000C;
      step();
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if ({pause, bus_req, bus_err} !== 3'b110) begin
            n_fail++;
            $display("FAIL timeout_wait[%0d]: pause %b req %b err %b expected 1 1 0",
                     i, pause, bus_req, bus_err);
         end
         step();
      end
      #1;
      n_checks++;
      if ({pause, bus_req, bus_err} !== 3'b001 || if_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL timeout_done: pause %b req %b err %b if_rdata %h expected 0 0 1 00000000",
                  pause, bus_req, bus_err, if_rdata);
      end
      if_req = 1'b0;
      step();
      #1;
      n_checks++;
      if (bus_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_pulse: err got %b expected 0", bus_err);
      end
   endtask
`endif

   task automatic test_reset_mid();
      if_req = 1'b1; if_addr = 32'h0040_0008;
      step();
      #1;
      n_checks++;
      if (bus_req !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_wait: req got %b expected 1", bus_req);
      end
      step();
      // Still waiting in FETCH; reset taken at the next edge.
      rst = 1'b1; if_req = 1'b0;
      step();
      rst = 1'b0;
      bus_ready = 1'b1; bus_rdata = 32'h0BAD_0BAD;
      #1;
      n_checks++;
      if ({pause, bus_req} !== 2'b00 || if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL rstmid_idle: pause %b req %b if_rdata %h mem_rdata %h expected 0 0 0 0",
                  pause, bus_req, if_rdata, mem_rdata);
      end
      step();
      bus_ready = 1'b0; bus_rdata = '0;
      #1;
      n_checks++;
      if ({pause, bus_req} !== 2'b00 || if_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL rstmid_late_ready: pause %b req %b if_rdata %h expected 0 0 0",
                  pause, bus_req, if_rdata);
      end
      step();
   endtask

   task automatic test_idle();
      idle_inputs();
      for (int i = 0; i < 10; i++) begin
         #1;
         n_checks++;
         if ({pause, bus_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle[%0d]: pause %b req %b expected 0 0", i, pause, bus_req);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_back_to_back();
      test_store_wait();
`ifdef BUS_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      test_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
      $fatal(1, "bench time limit expired");
   end

endmodule
